qpsk_frame_sequencer: RTL and testbench
=======================================

// Module: qpsk_frame_sequencer
// PURPOSE
//  Sequences one QPSK transmit frame: arms on start, aligns symbol 0 to the first one_sec_pulse coincident
//  with msf_carrier_pulse, emits a fixed-phase preamble, then streams data dibits from an AXI-stream FIFO,
//  one symbol per CP_PER_SYM carrier pulses. Drives the modulator phase input; sits between the TX FIFO
//  (clock-converted) and the carrier-locked modulator in the adc_clk domain.
// PARAMETERS
//  CNT_W      13   width of carrier-pulse-per-symbol counter
//  LEN_W      16   width of frame length / symbol counters
//  PRE_W       8   width of preamble length
// PORTS
//  clk                 in   1      adc_clk; all logic on rising edge
//  rst                 in   1      asynchronous, active-high reset
//  msf_carrier_pulse   in   1      one-cycle carrier tick
//  one_sec_pulse       in   1      second marker; only valid when coincident with msf_carrier_pulse
//  start               in   1      level; rising edge arms a frame (from control reg)
//  abort               in   1      one-cycle; terminates frame immediately
//  cfg_cp_per_sym      in   CNT_W  carrier pulses per symbol (3100 nominal)
//  cfg_pre_len         in   PRE_W  preamble symbols (0 = none)
//  cfg_pre_phase       in   2      preamble dibit
//  cfg_frame_len       in   LEN_W  data symbols per frame (0 = preamble only)
//  s_axis_tdata        in   2      data dibit
//  s_axis_tvalid       in   1
//  s_axis_tready       out  1      high whenever holding register empty and state is PREAMBLE or DATA
//  phase               out  2      current symbol phase to modulator
//  tx_en               out  1      modulator enable (high in PREAMBLE/DATA)
//  sym_strobe          out  1      one-cycle pulse when phase takes a new symbol
//  carrier_cnt         out  CNT_W  carrier pulses into current symbol
//  sym_cnt             out  LEN_W  data symbols issued this frame
//  busy / done         out  1      busy: ARMED..DATA; done: one-cycle pulse on frame completion
//  underrun            out  1      sticky; cleared by next start edge
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; holding register empty; counters 0.
//  cfg_* sampled into shadow regs on start rising edge; cfg_cp_per_sym 0 treated as 1.
//  States: IDLE -start edge-> ARMED -(pulse&one_sec)-> PREAMBLE (pre_len>0) else DATA -> DONE -> IDLE.
//  Boundary B: cycle with msf_carrier_pulse and (carrier_cnt==cp-1, or ARMED alignment event).
//   carrier_cnt resets to 0 at B, else +1 on each carrier pulse; holds between pulses.
//  At B (registered, visible B+1): phase, sym_strobe=1, tx_en=1.
//   PREAMBLE: phase=cfg_pre_phase; pre counter+1; after pre_len symbols next B enters DATA.
//   DATA: phase=holding reg, holding emptied, sym_cnt+1. After frame_len symbols, next B -> DONE.
//  Holding reg: one entry, filled when s_axis_tvalid&s_axis_tready; tready registered-free (comb from empty
//   & state). Fill and empty in same cycle (B): B empties, fill lands next cycle; no data lost.
//  Underrun: DATA boundary with holding empty -> underrun=1, phase=0, tx_en=0, go to DONE.
//  DONE: tx_en=0, phase=0, done pulse 1 cycle, return IDLE. frame_len 0 & pre_len 0 -> DONE at first B.
//  abort (any state but IDLE): next cycle IDLE, tx_en=0, phase=0, holding flushed, no done pulse. Abort wins
//   over simultaneous boundary. start held high does not re-arm; needs fresh rising edge.
//  one_sec_pulse during PREAMBLE/DATA ignored (no re-alignment).
//  Counters wrap-free: sym_cnt saturates at frame_len; carrier_cnt never exceeds cp-1.
// STRUCTURE
//  Package qpsk_tx_pkg: state enum (IDLE, ARMED, PREAMBLE, DATA, DONE), dibit typedef, PHASE_IDLE=2'b00.
//  Sub-module qpsk_sym_holding_reg: one-entry AXI-stream skid/holding register with pop input.
//  Top: FSM, carrier counter, preamble/symbol counters, cfg shadow regs.
// TESTING
//  1 cp=4, pre=2 (phase 3), len=3, data 1,2,0 preloaded; start, one_sec at pulse 10 -> phases 3,3,1,2,0
//    each 4 carrier pulses, sym_strobe x5, done one cycle after 5th symbol period ends, tx_en drops.
//  2 ARMED, one_sec without carrier pulse -> stays ARMED; next coincident pulse starts frame.
//  3 len=4, tvalid withheld before 3rd data symbol -> underrun=1 at that B, tx_en=0, sym_cnt=2, done pulse.
//  4 abort in mid DATA coincident with boundary -> IDLE next cycle, no sym_strobe, no done, tready=0.
//  5 cp=0 -> symbol every carrier pulse; pre=0,len=0 -> done at first aligned pulse, no sym_strobe.
//  6 rst asserted mid-DATA, asynchronous -> outputs 0 same edge-free; start held high after reset no re-arm.

Source files
------------

// File: rtl/qpsk_tx_pkg.sv
// Shared types for the QPSK transmit frame sequencer: FSM state encoding,
// the dibit symbol type and the phase driven while the modulator is idle.
package qpsk_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_ARMED    = 3'd1,
        TX_PREAMBLE = 3'd2,
        TX_DATA     = 3'd3,
        TX_DONE     = 3'd4
    } tx_state_e;

    typedef logic [1:0] dibit_t;

    localparam dibit_t PHASE_IDLE = 2'b00;

endpackage

// File: rtl/qpsk_sym_holding_reg.sv
// One-entry holding register between the TX FIFO stream and the symbol issue logic.
// Ready is purely combinational from the empty flag, so a pop and a refill never share a cycle.
module qpsk_sym_holding_reg
    import qpsk_tx_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   accept_en,
    input  logic   pop,
    input  dibit_t s_axis_tdata,
    input  logic   s_axis_tvalid,
    output logic   s_axis_tready,
    output logic   full,
    output dibit_t data
);

    assign s_axis_tready = accept_en && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= PHASE_IDLE;
        end else if (flush) begin
            full <= 1'b0;
        end else if (pop) begin
            full <= 1'b0;
        end else if (s_axis_tvalid && s_axis_tready) begin
            full <= 1'b1;
            data <= s_axis_tdata;
        end
    end

endmodule

// File: rtl/qpsk_frame_sequencer.sv
// Sequences one QPSK transmit frame: second-aligned start, fixed-phase preamble,
// then FIFO data dibits, one symbol per cp carrier pulses.
//   state    | meaning
//   IDLE     | waiting for a start rising edge
//   ARMED    | cfg captured, waiting for one_sec_pulse coincident with a carrier pulse
//   PREAMBLE | emitting cfg_pre_phase symbols
//   DATA     | emitting dibits from the holding register
//   DONE     | one-cycle completion, done pulse visible
module qpsk_frame_sequencer
    import qpsk_tx_pkg::*;
#(
    parameter int CNT_W = 13,
    parameter int LEN_W = 16,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msf_carrier_pulse,
    input  logic             one_sec_pulse,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_cp_per_sym,
    input  logic [PRE_W-1:0] cfg_pre_len,
    input  logic [1:0]       cfg_pre_phase,
    input  logic [LEN_W-1:0] cfg_frame_len,
    input  logic [1:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [1:0]       phase,
    output logic             tx_en,
    output logic             sym_strobe,
    output logic [CNT_W-1:0] carrier_cnt,
    output logic [LEN_W-1:0] sym_cnt,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam logic [2:0] S_IDLE     = TX_IDLE;
    localparam logic [2:0] S_ARMED    = TX_ARMED;
    localparam logic [2:0] S_PREAMBLE = TX_PREAMBLE;
    localparam logic [2:0] S_DATA     = TX_DATA;
    localparam logic [2:0] S_DONE     = TX_DONE;

    logic [2:0]       state;
    logic             start_d;
    logic             start_rise;
    logic [CNT_W-1:0] cp_sh;
    logic [PRE_W-1:0] pre_len_sh;
    dibit_t           pre_phase_sh;
    logic [LEN_W-1:0] frame_len_sh;
    logic [PRE_W-1:0] pre_cnt;

    logic             active;
    logic             align;
    logic             sym_end;
    logic             boundary;
    logic             abort_hit;
    logic             issue_pre;
    logic             issue_data;

    logic             hold_full;
    dibit_t           hold_data;
    logic             hold_pop;

    assign start_rise = start && !start_d;
    assign active     = (state == S_PREAMBLE) || (state == S_DATA);
    assign busy       = (state == S_ARMED) || active;
    assign abort_hit  = abort && (state != S_IDLE);
    assign align      = (state == S_ARMED) && msf_carrier_pulse && one_sec_pulse;
    assign sym_end    = active && msf_carrier_pulse && (carrier_cnt == cp_sh - CNT_W'(1));
    assign boundary   = align || sym_end;

    // The counters start at zero in ARMED, so the same issue decision covers symbol 0.
    assign issue_pre  = (pre_cnt < pre_len_sh);
    assign issue_data = !issue_pre && (sym_cnt < frame_len_sh);
    assign hold_pop   = boundary && !abort_hit && issue_data && hold_full;

    qpsk_sym_holding_reg u_hold (
        .clk           (clk),
        .rst           (rst),
        .flush         (abort_hit),
        .accept_en     (active),
        .pop           (hold_pop),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .full          (hold_full),
        .data          (hold_data)
    );

    // start_d resets high so a start level held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            start_d      <= 1'b1;
            cp_sh        <= CNT_W'(1);
            pre_len_sh   <= '0;
            pre_phase_sh <= PHASE_IDLE;
            frame_len_sh <= '0;
            pre_cnt      <= '0;
            sym_cnt      <= '0;
            carrier_cnt  <= '0;
            phase        <= PHASE_IDLE;
            tx_en        <= 1'b0;
            sym_strobe   <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            start_d    <= start;
            sym_strobe <= 1'b0;
            done       <= 1'b0;
            if (abort_hit) begin
                state       <= S_IDLE;
                tx_en       <= 1'b0;
                phase       <= PHASE_IDLE;
                carrier_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_rise) begin
                            state        <= S_ARMED;
                            cp_sh        <= (cfg_cp_per_sym == '0) ? CNT_W'(1) : cfg_cp_per_sym;
                            pre_len_sh   <= cfg_pre_len;
                            pre_phase_sh <= cfg_pre_phase;
                            frame_len_sh <= cfg_frame_len;
                            pre_cnt      <= '0;
                            sym_cnt      <= '0;
                            carrier_cnt  <= '0;
                            underrun     <= 1'b0;
                        end
                    end
                    S_ARMED, S_PREAMBLE, S_DATA: begin
                        if (boundary) begin
                            carrier_cnt <= '0;
                            if (issue_pre) begin
                                state      <= S_PREAMBLE;
                                phase      <= pre_phase_sh;
                                tx_en      <= 1'b1;
                                sym_strobe <= 1'b1;
                                pre_cnt    <= pre_cnt + PRE_W'(1);
                            end else if (issue_data && hold_full) begin
                                state      <= S_DATA;
                                phase      <= hold_data;
                                tx_en      <= 1'b1;
                                sym_strobe <= 1'b1;
                                sym_cnt    <= sym_cnt + LEN_W'(1);
                            end else begin
                                state <= S_DONE;
                                phase <= PHASE_IDLE;
                                tx_en <= 1'b0;
                                done  <= 1'b1;
                                if (issue_data) begin
                                    underrun <= 1'b1;
                                end
                            end
                        end else if (msf_carrier_pulse && active) begin
                            carrier_cnt <= carrier_cnt + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qpsk_frame_sequencer.sv
// Self-checking bench for qpsk_frame_sequencer: randomized carrier timing and data,
// expectations from a symbol-index model of the frame (symbol k starts at aligned pulse k*cp).
module tb_qpsk_frame_sequencer;
    import qpsk_tx_pkg::*;

    localparam int CNT_W = 13;
    localparam int LEN_W = 16;
    localparam int PRE_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             msf_carrier_pulse;
    logic             one_sec_pulse;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_cp_per_sym;
    logic [PRE_W-1:0] cfg_pre_len;
    logic [1:0]       cfg_pre_phase;
    logic [LEN_W-1:0] cfg_frame_len;
    logic [1:0]       s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [1:0]       phase;
    logic             tx_en;
    logic             sym_strobe;
    logic [CNT_W-1:0] carrier_cnt;
    logic [LEN_W-1:0] sym_cnt;
    logic             busy;
    logic             done;
    logic             underrun;

    int checks   = 0;
    int failures = 0;

    logic [1:0] src_q[$];
    logic       hs;

    always #5 clk = ~clk;

    qpsk_frame_sequencer #(.CNT_W(CNT_W), .LEN_W(LEN_W), .PRE_W(PRE_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .msf_carrier_pulse (msf_carrier_pulse),
        .one_sec_pulse     (one_sec_pulse),
        .start             (start),
        .abort             (abort),
        .cfg_cp_per_sym    (cfg_cp_per_sym),
        .cfg_pre_len       (cfg_pre_len),
        .cfg_pre_phase     (cfg_pre_phase),
        .cfg_frame_len     (cfg_frame_len),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .phase             (phase),
        .tx_en             (tx_en),
        .sym_strobe        (sym_strobe),
        .carrier_cnt       (carrier_cnt),
        .sym_cnt           (sym_cnt),
        .busy              (busy),
        .done              (done),
        .underrun          (underrun)
    );

    // Advance one clock; the source queue behaves like the TX FIFO feeding the stream.
    task automatic step();
        hs = s_axis_tvalid && s_axis_tready;
        @(posedge clk);
        #1;
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        s_axis_tvalid = (src_q.size() > 0);
        s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : 2'b00;
    endtask

    task automatic run_frame(input string tag, input int cp_cfg, input int pre, input int pph,
                             input logic [1:0] dat[$], input int n_avail, input int lead,
                             input int abort_k, input bit stray_sec);
        int         cp, len, p, k, j, gap, tail, exp_cc, exp_sym, lead_left;
        bit         aligned, ended, exp_strobe, exp_done, exp_ur, exp_tx, exp_busy;
        logic [1:0] exp_phase;
        cp        = (cp_cfg == 0) ? 1 : cp_cfg;
        len       = dat.size();
        lead_left = lead;
        src_q.delete();
        for (int i = 0; i < n_avail; i++) src_q.push_back(dat[i]);
        s_axis_tvalid  = (src_q.size() > 0);
        s_axis_tdata   = (src_q.size() > 0) ? src_q[0] : 2'b00;
        cfg_cp_per_sym = CNT_W'(cp_cfg);
        cfg_pre_len    = PRE_W'(pre);
        cfg_pre_phase  = 2'(pph);
        cfg_frame_len  = LEN_W'(len);
        msf_carrier_pulse = 1'b0;
        one_sec_pulse     = 1'b0;
        abort             = 1'b0;
        start             = 1'b0;
        step();
        start = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || underrun !== 1'b0)
            begin failures++; $display("FAIL %s_arm busy=%b underrun=%b exp busy=1 underrun=0", tag, busy, underrun); end
        // Frame must run on the configuration captured at the start edge.
        cfg_cp_per_sym = CNT_W'($urandom);
        cfg_pre_len    = PRE_W'($urandom);
        cfg_pre_phase  = 2'($urandom);
        cfg_frame_len  = LEN_W'($urandom);

        aligned = 0; ended = 0; exp_ur = 0; exp_tx = 0; exp_phase = 2'b00;
        exp_sym = 0; p = 0; tail = 0; gap = $urandom_range(1, 3);
        for (int c = 0; c < 4000 && tail < 3; c++) begin
            msf_carrier_pulse = (gap == 0);
            gap = (gap == 0) ? $urandom_range(1, 3) : gap - 1;
            one_sec_pulse = 1'b0;
            abort         = 1'b0;
            exp_strobe    = 0;
            exp_done      = 0;
            if (!ended) begin
                if (msf_carrier_pulse) begin
                    if (!aligned) begin
                        if (lead_left == 0) begin
                            one_sec_pulse = 1'b1;
                            aligned = 1;
                            p = 0;
                        end else begin
                            lead_left--;
                        end
                    end else begin
                        p++;
                        if (stray_sec) one_sec_pulse = 1'($urandom_range(0, 1));
                    end
                    if (aligned && (p % cp) == 0) begin
                        k = p / cp;
                        j = k - pre;
                        if (k == abort_k) begin
                            abort = 1'b1; ended = 1; exp_tx = 0; exp_phase = 2'b00;
                        end else if (k < pre) begin
                            exp_strobe = 1; exp_tx = 1; exp_phase = 2'(pph);
                        end else if (k < pre + len && j < n_avail) begin
                            exp_strobe = 1; exp_tx = 1; exp_phase = dat[j]; exp_sym++;
                        end else begin
                            exp_done = 1; ended = 1; exp_tx = 0; exp_phase = 2'b00;
                            exp_ur = (k < pre + len);
                        end
                    end
                end else if (!aligned && stray_sec && (c % 2) == 0) begin
                    one_sec_pulse = 1'b1;
                end
            end
            exp_busy = !ended;
            exp_cc   = (aligned && !ended) ? (p % cp) : 0;
            step();
            checks++;
            if ({sym_strobe, done, tx_en, phase, busy} !== {exp_strobe, exp_done, exp_tx, exp_phase, exp_busy}) begin
                failures++;
                $display("FAIL %s_outputs t=%0d strobe,done,tx_en,phase,busy got=%b exp=%b", tag, c,
                         {sym_strobe, done, tx_en, phase, busy}, {exp_strobe, exp_done, exp_tx, exp_phase, exp_busy});
            end
            checks++;
            if (carrier_cnt !== CNT_W'(exp_cc) || sym_cnt !== LEN_W'(exp_sym)) begin
                failures++;
                $display("FAIL %s_counters t=%0d carrier_cnt=%0d sym_cnt=%0d exp %0d %0d", tag, c,
                         carrier_cnt, sym_cnt, exp_cc, exp_sym);
            end
            if (ended || !aligned) begin
                checks++;
                if (s_axis_tready !== 1'b0)
                    begin failures++; $display("FAIL %s_tready t=%0d got=%b exp=0", tag, c, s_axis_tready); end
            end
            if (ended) tail++;
        end
        msf_carrier_pulse = 1'b0;
        one_sec_pulse     = 1'b0;
        abort             = 1'b0;
        checks++;
        if (!ended)
            begin failures++; $display("FAIL %s_timeout frame end not reached got=0 exp=1", tag); end
        checks++;
        if (underrun !== exp_ur)
            begin failures++; $display("FAIL %s_underrun got=%b exp=%b", tag, underrun, exp_ur); end
        start = 1'b0;
        src_q.delete();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({phase, tx_en, sym_strobe, carrier_cnt, sym_cnt, busy, done, underrun, s_axis_tready} !== '0)
            begin failures++; $display("FAIL reset_in got phase=%0d tx_en=%b busy=%b exp all 0", phase, tx_en, busy); end
        rst = 1'b0;
        step();
        checks++;
        if ({phase, tx_en, sym_strobe, carrier_cnt, sym_cnt, busy, done, underrun, s_axis_tready} !== '0)
            begin failures++; $display("FAIL reset_out got phase=%0d tx_en=%b busy=%b exp all 0", phase, tx_en, busy); end
    endtask

    task automatic test_basic_frame();
        logic [1:0] d[$];
        d = '{2'd1, 2'd2, 2'd0};
        run_frame("basic", 4, 2, 3, d, 3, 9, -1, 1'b0);
    endtask

    task automatic test_armed_alignment();
        logic [1:0] d[$];
        for (int i = 0; i < 3; i++) d.push_back(2'($urandom_range(0, 3)));
        run_frame("align", 3, 1, $urandom_range(0, 3), d, 3, 3, -1, 1'b1);
    endtask

    task automatic test_underrun();
        logic [1:0] d[$];
        for (int i = 0; i < 4; i++) d.push_back(2'($urandom_range(0, 3)));
        run_frame("underrun", 3, 1, 2, d, 2, 1, -1, 1'b0);
    endtask

    task automatic test_abort();
        logic [1:0] d[$];
        for (int i = 0; i < 5; i++) d.push_back(2'($urandom_range(0, 3)));
        run_frame("abort", 3, 1, 1, d, 5, 0, 3, 1'b0);
    endtask

    task automatic test_cp_zero();
        logic [1:0] d[$];
        for (int i = 0; i < 3; i++) d.push_back(2'($urandom_range(0, 3)));
        run_frame("cp_zero", 0, 1, 3, d, 3, 1, -1, 1'b0);
        d.delete();
        run_frame("empty_frame", 0, 0, 2, d, 0, 2, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] d[$];
        int         len;
        for (int f = 0; f < 8; f++) begin
            d.delete();
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) d.push_back(2'($urandom_range(0, 3)));
            run_frame("rand", $urandom_range(0, 5), $urandom_range(1, 3), $urandom_range(0, 3),
                      d, len, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_async_reset();
        bit reached;
        src_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(2'($urandom_range(0, 3)));
        cfg_cp_per_sym = CNT_W'(2);
        cfg_pre_len    = PRE_W'(1);
        cfg_pre_phase  = 2'd2;
        cfg_frame_len  = LEN_W'(4);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        reached = 0;
        for (int c = 0; c < 60 && !reached; c++) begin
            msf_carrier_pulse = ((c % 3) == 0);
            one_sec_pulse     = (c == 0);
            step();
            reached = (sym_cnt != '0);
        end
        msf_carrier_pulse = 1'b0;
        one_sec_pulse     = 1'b0;
        checks++;
        if (!reached || tx_en !== 1'b1)
            begin failures++; $display("FAIL rst_setup data phase got tx_en=%b sym_cnt=%0d exp tx_en=1 sym_cnt>0", tx_en, sym_cnt); end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({phase, tx_en, sym_strobe, carrier_cnt, sym_cnt, busy, done, underrun, s_axis_tready} !== '0)
            begin failures++; $display("FAIL rst_async got tx_en=%b busy=%b sym_cnt=%0d exp all 0", tx_en, busy, sym_cnt); end
        src_q.delete();
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            msf_carrier_pulse = ((c % 2) == 0);
            one_sec_pulse     = ((c % 2) == 0);
            step();
            checks++;
            if (busy !== 1'b0 || sym_strobe !== 1'b0 || tx_en !== 1'b0)
                begin failures++; $display("FAIL rst_no_rearm t=%0d busy=%b strobe=%b tx_en=%b exp 0", c, busy, sym_strobe, tx_en); end
        end
        msf_carrier_pulse = 1'b0;
        one_sec_pulse     = 1'b0;
        start = 1'b0;
        step();
    endtask

    initial begin
        rst               = 1'b1;
        msf_carrier_pulse = 1'b0;
        one_sec_pulse     = 1'b0;
        start             = 1'b0;
        abort             = 1'b0;
        cfg_cp_per_sym    = '0;
        cfg_pre_len       = '0;
        cfg_pre_phase     = 2'b00;
        cfg_frame_len     = '0;
        s_axis_tdata      = 2'b00;
        s_axis_tvalid     = 1'b0;
        test_reset();
        test_basic_frame();
        test_armed_alignment();
        test_underrun();
        test_abort();
        test_cp_zero();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
